// File: rtl/sobel_edge_proc.sv
// sobel_edge_proc
//   3x3 Sobel edge detector on the camera pixel clock. Takes the gray stream from the
//   capture block and emits a binary edge flag plus a saturated gradient magnitude.
//   The sync flags are delayed by the same 4 clocks as the data.
//
// Ports
//   clk               pixel clock
//   rst               synchronous reset, active high
//   per_frame_vsync   input vsync (high between frames)
//   per_frame_href    input line valid
//   per_frame_clken   input pixel strobe
//   per_img_gray      input gray pixel, PIX_W bits
//   mode              0/3 Sobel, 1 gray threshold, 2 inverted Sobel
//   threshold         compare level, used by the pixel entering the last stage
//   post_frame_vsync  vsync delayed 4 clocks
//   post_frame_href   href delayed 4 clocks
//   post_frame_clken  clken delayed 4 clocks
//   post_img_bit      edge / threshold flag (value > threshold)
//   post_img_mag      min(|Gx|+|Gy|, 2^PIX_W-1); in mode 1 the window centre gray
//
// Optional feature, enabled by defining SOBEL_BBOX_EN:
//   bbox_valid, bbox_empty, bbox_xmin/xmax, bbox_ymin/ymax: per-frame bounding box of the
//   window centres whose post_img_bit is 1, latched on the post_frame_vsync rising edge.
//   Border-masked pixels have no real centre and are never tracked.
//
// Output pixel for input (x,y) is centred at (x-1,y-1). Inputs with x<2 or y<2 are border:
// bit 0 (1 in mode 2), mag 0, in every mode. Line-buffer RAM is not reset; the border rule
// hides its stale contents.

module sobel_edge_proc #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       per_frame_vsync,
  input  logic                       per_frame_href,
  input  logic                       per_frame_clken,
  input  logic [PIX_W-1:0]           per_img_gray,
  input  logic [1:0]                 mode,
  input  logic [PIX_W-1:0]           threshold,
  output logic                       post_frame_vsync,
  output logic                       post_frame_href,
  output logic                       post_frame_clken,
  output logic                       post_img_bit,
  output logic [PIX_W-1:0]           post_img_mag
`ifdef SOBEL_BBOX_EN
  ,
  output logic                       bbox_valid,
  output logic                       bbox_empty,
  output logic [$clog2(IMG_W)-1:0]   bbox_xmin,
  output logic [$clog2(IMG_W)-1:0]   bbox_xmax,
  output logic [$clog2(IMG_H)-1:0]   bbox_ymin,
  output logic [$clog2(IMG_H)-1:0]   bbox_ymax
`endif
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned GW = PIX_W + 3;  // signed gradient
  localparam int unsigned MW = PIX_W + 4;  // |Gx|+|Gy| before saturation
  localparam logic [XW-1:0]    X_MAX   = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    Y_MAX   = YW'(IMG_H - 1);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  // ---------------------------------------------------------------------------------------
  // Position counters
  // ---------------------------------------------------------------------------------------
  logic          r_href_q, r_vsync_q;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_x_sat;  // line already held IMG_W pixels; further ones are dropped
  logic          w_pix, w_wr, w_href_fall, w_vs_rise, w_border;

  assign w_pix       = per_frame_clken & per_frame_href;
  assign w_wr        = w_pix & ~r_x_sat;
  assign w_href_fall = r_href_q & ~per_frame_href;
  assign w_vs_rise   = per_frame_vsync & ~r_vsync_q;
  assign w_border    = (r_x < XW'(2)) | (r_y < YW'(2)) | r_x_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_href_q  <= 1'b0;
      r_vsync_q <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_x_sat   <= 1'b0;
    end else begin
      r_href_q  <= per_frame_href;
      r_vsync_q <= per_frame_vsync;
      if (w_vs_rise) begin
        r_x     <= '0;
        r_x_sat <= 1'b0;
        r_y     <= '0;
      end else if (w_href_fall) begin
        r_x     <= '0;
        r_x_sat <= 1'b0;
        if (r_y != Y_MAX) r_y <= r_y + YW'(1);
      end else if (w_pix) begin
        if (r_x == X_MAX) r_x_sat <= 1'b1;
        else              r_x     <= r_x + XW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Line buffers: r_lb1 holds row y-1, r_lb2 row y-2 (asynchronous read at r_x)
  // ---------------------------------------------------------------------------------------
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] r_lb2 [IMG_W];
  logic [PIX_W-1:0] w_top, w_mid;

  assign w_top = r_lb2[r_x];
  assign w_mid = r_lb1[r_x];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_lb1[r_x] <= per_img_gray;
      r_lb2[r_x] <= w_mid;
    end
  end

  // ---------------------------------------------------------------------------------------
  // S1: window shift. r_win[row][col], row 0 = y-2, col 0 = x-2, col 2 = newest.
  // ---------------------------------------------------------------------------------------
  logic [PIX_W-1:0] r_win [3][3];
  logic             r_s1_vld, r_s1_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
      end
      r_s1_vld  <= 1'b0;
      r_s1_mask <= 1'b1;
    end else begin
      r_s1_vld  <= w_pix;
      r_s1_mask <= w_border;
      if (w_wr) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_top;
        r_win[1][2] <= w_mid;
        r_win[2][2] <= per_img_gray;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // S2: gradients, kept as two's complement in GW bits
  // ---------------------------------------------------------------------------------------
  logic [GW-1:0]    w_gx, w_gy;
  logic [GW-1:0]    r_s2_gx, r_s2_gy;
  logic [PIX_W-1:0] r_s2_gray;
  logic             r_s2_vld, r_s2_mask;

  always_comb begin
    w_gx = (GW'(r_win[0][2]) + (GW'(r_win[1][2]) << 1) + GW'(r_win[2][2]))
         - (GW'(r_win[0][0]) + (GW'(r_win[1][0]) << 1) + GW'(r_win[2][0]));
    w_gy = (GW'(r_win[2][0]) + (GW'(r_win[2][1]) << 1) + GW'(r_win[2][2]))
         - (GW'(r_win[0][0]) + (GW'(r_win[0][1]) << 1) + GW'(r_win[0][2]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_gx   <= '0;
      r_s2_gy   <= '0;
      r_s2_gray <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_mask <= 1'b1;
    end else begin
      r_s2_gx   <= w_gx;
      r_s2_gy   <= w_gy;
      r_s2_gray <= r_win[1][1];
      r_s2_vld  <= r_s1_vld;
      r_s2_mask <= r_s1_mask;
    end
  end

  // ---------------------------------------------------------------------------------------
  // S3: |Gx|+|Gy| saturated to PIX_W bits
  // ---------------------------------------------------------------------------------------
  logic [GW-1:0]    w_ax, w_ay;
  logic [MW-1:0]    w_sum;
  logic [PIX_W-1:0] w_sat;
  logic [PIX_W-1:0] r_s3_mag, r_s3_gray;
  logic             r_s3_vld, r_s3_mask;

  always_comb begin
    // |G| <= 4*(2^PIX_W-1) fits in GW-1 bits, so negation cannot overflow
    w_ax  = r_s2_gx[GW-1] ? (~r_s2_gx + GW'(1)) : r_s2_gx;
    w_ay  = r_s2_gy[GW-1] ? (~r_s2_gy + GW'(1)) : r_s2_gy;
    w_sum = MW'(w_ax) + MW'(w_ay);
    w_sat = (w_sum > {4'b0000, PIX_MAX}) ? PIX_MAX : w_sum[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_mag  <= '0;
      r_s3_gray <= '0;
      r_s3_vld  <= 1'b0;
      r_s3_mask <= 1'b1;
    end else begin
      r_s3_mag  <= w_sat;
      r_s3_gray <= r_s2_gray;
      r_s3_vld  <= r_s2_vld;
      r_s3_mask <= r_s2_mask;
    end
  end

  // ---------------------------------------------------------------------------------------
  // S4: mode mux and compare; mode/threshold act on whatever pixel is here now
  // ---------------------------------------------------------------------------------------
  logic [PIX_W-1:0] w_val, w_mag;
  logic             w_gt, w_bit;
  logic             r_bit;
  logic [PIX_W-1:0] r_mag;
  logic [2:0]       r_sync [4];  // {vsync, href, clken}

  always_comb begin
    w_val = (mode == 2'd1) ? r_s3_gray : r_s3_mag;
    w_gt  = w_val > threshold;
    w_bit = 1'b0;
    w_mag = '0;
    if (r_s3_vld) begin
      if (r_s3_mask) begin
        w_bit = (mode == 2'd2);
      end else begin
        w_bit = (mode == 2'd2) ? ~w_gt : w_gt;
        w_mag = w_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit <= 1'b0;
      r_mag <= '0;
      for (int i = 0; i < 4; i++) r_sync[i] <= '0;
    end else begin
      r_bit     <= w_bit;
      r_mag     <= w_mag;
      r_sync[0] <= {per_frame_vsync, per_frame_href, per_frame_clken};
      for (int i = 1; i < 4; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign post_frame_vsync = r_sync[3][2];
  assign post_frame_href  = r_sync[3][1];
  assign post_frame_clken = r_sync[3][0];
  assign post_img_bit     = r_bit;
  assign post_img_mag     = r_mag;

`ifdef SOBEL_BBOX_EN
  // ---------------------------------------------------------------------------------------
  // Bounding box of edge centres
  // ---------------------------------------------------------------------------------------
  logic [XW-1:0] r_s1_cx, r_s2_cx, r_s3_cx;
  logic [YW-1:0] r_s1_cy, r_s2_cy, r_s3_cy;
  logic          r_t_any, w_t_any;
  logic [XW-1:0] r_t_xmin, r_t_xmax, w_t_xmin, w_t_xmax;
  logic [YW-1:0] r_t_ymin, r_t_ymax, w_t_ymin, w_t_ymax;
  logic          w_hit, w_vs_out_rise;
  logic          r_bb_valid, r_bb_empty;
  logic [XW-1:0] r_bb_xmin, r_bb_xmax;
  logic [YW-1:0] r_bb_ymin, r_bb_ymax;

  // Coordinates wrap for border pixels, but those are masked and never tracked
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_cx <= '0;
      r_s2_cx <= '0;
      r_s3_cx <= '0;
      r_s1_cy <= '0;
      r_s2_cy <= '0;
      r_s3_cy <= '0;
    end else begin
      r_s1_cx <= r_x - XW'(1);
      r_s2_cx <= r_s1_cx;
      r_s3_cx <= r_s2_cx;
      r_s1_cy <= r_y - YW'(1);
      r_s2_cy <= r_s1_cy;
      r_s3_cy <= r_s2_cy;
    end
  end

  assign w_hit         = w_bit & r_s3_vld & ~r_s3_mask;
  // Same edge that raises post_frame_vsync
  assign w_vs_out_rise = r_sync[2][2] & ~r_sync[3][2];

  always_comb begin
    w_t_any  = r_t_any;
    w_t_xmin = r_t_xmin;
    w_t_xmax = r_t_xmax;
    w_t_ymin = r_t_ymin;
    w_t_ymax = r_t_ymax;
    if (w_hit) begin
      w_t_any = 1'b1;
      if (!r_t_any || r_s3_cx < r_t_xmin) w_t_xmin = r_s3_cx;
      if (!r_t_any || r_s3_cx > r_t_xmax) w_t_xmax = r_s3_cx;
      if (!r_t_any || r_s3_cy < r_t_ymin) w_t_ymin = r_s3_cy;
      if (!r_t_any || r_s3_cy > r_t_ymax) w_t_ymax = r_s3_cy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_t_any    <= 1'b0;
      r_t_xmin   <= '0;
      r_t_xmax   <= '0;
      r_t_ymin   <= '0;
      r_t_ymax   <= '0;
      r_bb_valid <= 1'b0;
      r_bb_empty <= 1'b0;
      r_bb_xmin  <= '0;
      r_bb_xmax  <= '0;
      r_bb_ymin  <= '0;
      r_bb_ymax  <= '0;
    end else begin
      r_bb_valid <= w_vs_out_rise;
      if (w_vs_out_rise) begin
        r_bb_empty <= ~w_t_any;
        r_bb_xmin  <= w_t_any ? w_t_xmin : '0;
        r_bb_xmax  <= w_t_any ? w_t_xmax : '0;
        r_bb_ymin  <= w_t_any ? w_t_ymin : '0;
        r_bb_ymax  <= w_t_any ? w_t_ymax : '0;
        r_t_any    <= 1'b0;
      end else begin
        r_t_any  <= w_t_any;
        r_t_xmin <= w_t_xmin;
        r_t_xmax <= w_t_xmax;
        r_t_ymin <= w_t_ymin;
        r_t_ymax <= w_t_ymax;
      end
    end
  end

  assign bbox_valid = r_bb_valid;
  assign bbox_empty = r_bb_empty;
  assign bbox_xmin  = r_bb_xmin;
  assign bbox_xmax  = r_bb_xmax;
  assign bbox_ymin  = r_bb_ymin;
  assign bbox_ymax  = r_bb_ymax;
`endif

endmodule

// File: tb/tb_sobel_edge_proc.sv
// Scoreboard bench for sobel_edge_proc: the driver computes each pixel's expected result
// from a whole-frame image model and queues it; a negedge monitor pops on every output pixel.
module tb_sobel_edge_proc;

  localparam int PIX_W = 8;
  localparam int IMG_W = 16;
  localparam int IMG_H = 8;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             vsync = 1'b0, href = 1'b0, clken = 1'b0;
  logic [PIX_W-1:0] gray = '0, thr = '0;
  logic [1:0]       mode = '0;
  logic             post_vs, post_href, post_clken, post_bit;
  logic [PIX_W-1:0] post_mag;
`ifdef SOBEL_BBOX_EN
  logic             bb_valid, bb_empty;
  logic [XW-1:0]    bb_xmin, bb_xmax;
  logic [YW-1:0]    bb_ymin, bb_ymax;
  logic [2*XW+2*YW:0] bbq[$];
  int               m_any, m_xmin, m_xmax, m_ymin, m_ymax;
`endif

  int checks = 0;
  int failures = 0;
  int img [IMG_H][IMG_W];
  int cur_mode, cur_thr;
  logic [PIX_W:0] sb[$];     // {bit, mag}
  logic [3:0]     hist[$];   // {rst, vsync, href, clken}, newest first

  sobel_edge_proc #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk              (clk),
    .rst              (rst),
    .per_frame_vsync  (vsync),
    .per_frame_href   (href),
    .per_frame_clken  (clken),
    .per_img_gray     (gray),
    .mode             (mode),
    .threshold        (thr),
    .post_frame_vsync (post_vs),
    .post_frame_href  (post_href),
    .post_frame_clken (post_clken),
    .post_img_bit     (post_bit),
    .post_img_mag     (post_mag)
`ifdef SOBEL_BBOX_EN
    ,
    .bbox_valid       (bb_valid),
    .bbox_empty       (bb_empty),
    .bbox_xmin        (bb_xmin),
    .bbox_xmax        (bb_xmax),
    .bbox_ymin        (bb_ymin),
    .bbox_ymax        (bb_ymax)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: textbook Sobel on the stored frame, centre (x-1,y-1)
  function automatic logic [PIX_W:0] ref_pix(input int x, input int y);
    int gx, gy, s, v;
    logic b;
    if (x < 2 || y < 2) return {cur_mode == 2, {PIX_W{1'b0}}};
    gx = (img[y-2][x] + 2*img[y-1][x] + img[y][x])
       - (img[y-2][x-2] + 2*img[y-1][x-2] + img[y][x-2]);
    gy = (img[y][x-2] + 2*img[y][x-1] + img[y][x])
       - (img[y-2][x-2] + 2*img[y-2][x-1] + img[y-2][x]);
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (s > 255) s = 255;
    v = (cur_mode == 1) ? img[y-1][x-1] : s;
    b = (v > cur_thr);
    if (cur_mode == 2) b = !b;
    return {b, PIX_W'(v)};
  endfunction

  task automatic push_exp(input int x, input int y);
    logic [PIX_W:0] e;
    e = ref_pix(x, y);
    sb.push_back(e);
`ifdef SOBEL_BBOX_EN
    if (e[PIX_W] && x >= 2 && y >= 2) begin
      if (m_any == 0 || x-1 < m_xmin) m_xmin = x-1;
      if (m_any == 0 || x-1 > m_xmax) m_xmax = x-1;
      if (m_any == 0 || y-1 < m_ymin) m_ymin = y-1;
      if (m_any == 0 || y-1 > m_ymax) m_ymax = y-1;
      m_any = 1;
    end
`endif
  endtask

  task automatic start_vsync(input int md, input int th);
`ifdef SOBEL_BBOX_EN
    if (m_any != 0)
      bbq.push_back({1'b0, XW'(m_xmin), XW'(m_xmax), YW'(m_ymin), YW'(m_ymax)});
    else
      bbq.push_back({1'b1, {(2*XW+2*YW){1'b0}}});
    m_any = 0;
`endif
    cur_mode = md;
    cur_thr  = th;
    mode     = md[1:0];
    thr      = th[PIX_W-1:0];
    vsync    = 1'b1;
    repeat (3) tick();
    vsync    = 1'b0;
    repeat (2) tick();
  endtask

  // pat: 0 flat 0x80, 1 step at col 8, 2 ramp x, 3 random, 4 sparse dots
  task automatic send_frame(input int pat, input int md, input int th,
                            input int rst_y, input int rst_x);
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        case (pat)
          0:       img[y][x] = 128;
          1:       img[y][x] = (x >= 8) ? 255 : 0;
          2:       img[y][x] = x;
          3:       img[y][x] = int'($urandom_range(0, 255));
          default: img[y][x] = ($urandom_range(0, 7) == 0) ? 255 : 0;
        endcase
      end
    end
    start_vsync(md, th);
    for (int y = 0; y < IMG_H; y++) begin
      href = 1'b1;
      for (int x = 0; x < IMG_W; x++) begin
        for (int k = 0; k < 3 && $urandom_range(0, 3) == 0; k++) begin
          clken = 1'b0;
          tick();
        end
        clken = 1'b1;
        gray  = PIX_W'(img[y][x]);
        push_exp(x, y);
        if (y == rst_y && x == rst_x) begin
          rst = 1'b1;
          tick();
          rst   = 1'b0;
          clken = 1'b0;
          href  = 1'b0;
          check("outputs_after_rst", {post_vs, post_href, post_clken, post_bit, post_mag}, 0);
`ifdef SOBEL_BBOX_EN
          check("bbox_after_rst", {bb_valid, bb_empty, bb_xmin, bb_xmax, bb_ymin, bb_ymax}, 0);
          m_any = 0;
`endif
          repeat (8) tick();
          sb.delete();  // pixels in flight at reset are discarded by design
          return;
        end
        tick();
      end
      clken = 1'b0;
      href  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        clken = (i == 1) && ($urandom_range(0, 1) == 1);  // strobe outside href
        tick();
      end
      clken = 1'b0;
    end
    repeat (6) tick();
  endtask

  always @(posedge clk) begin
    hist.push_front({rst, vsync, href, clken});
    if (hist.size() > 6) hist.delete(hist.size() - 1);
  end

  always @(negedge clk) begin
    logic [PIX_W:0] e;
    logic [2:0]     es;
    if (hist.size() >= 4) begin
      es = (hist[0][3] | hist[1][3] | hist[2][3] | hist[3][3]) ? 3'b000 : hist[3][2:0];
      check("sync_delay", {post_vs, post_href, post_clken}, es);
    end
    if (post_clken && post_href) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pixel_unexpected actual=output_pixel required=none at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("pixel_bit_mag", {post_bit, post_mag}, e);
      end
    end
`ifdef SOBEL_BBOX_EN
    if (bb_valid) begin
      if (bbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bbox_unexpected actual=bbox_valid required=none at %0t", $time);
      end else begin
        check("bbox", {bb_empty, bb_xmin, bb_xmax, bb_ymin, bb_ymax}, bbq.pop_front());
      end
    end
`endif
  end

  initial begin
`ifdef SOBEL_BBOX_EN
    m_any = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
`endif
    cur_mode = 0;
    cur_thr  = 0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {post_vs, post_href, post_clken, post_bit, post_mag}, 0);
    rst = 1'b0;
    tick();

    send_frame(0, 0, 128, -1, -1);   // flat gray
    send_frame(1, 0, 128, -1, -1);   // vertical step
    send_frame(2, 1, 10,  -1, -1);   // gray threshold on ramp
    send_frame(1, 2, 128, -1, -1);   // inverted Sobel
    send_frame(1, 0, 128, 3, 5);     // reset mid-line 3
    send_frame(1, 0, 128, -1, -1);   // first frame after reset
    send_frame(3, 3, 100, -1, -1);   // mode 3 aliases Sobel
    for (int f = 0; f < 6; f++)
      send_frame(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)), -1, -1);
    send_frame(1, 0, 128, -1, -1);   // step again; its bbox is latched by the final vsync
    start_vsync(0, 128);
    repeat (10) tick();

    check("scoreboard_drained", sb.size(), 0);
`ifdef SOBEL_BBOX_EN
    check("bbox_queue_drained", bbq.size(), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
